// File: rtl/ysyx_24090012_lsu_pkg.sv
// Shared definitions for the load/store unit.
// Contents: RISC-V LOAD/STORE opcodes, funct3 codes, access-size codes, the LSU state
// encoding and two decode helpers used on the accept path.
package ysyx_24090012_lsu_pkg;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  // funct3 codes; stores share the low three (SB/SH/SW).
  localparam logic [2:0] F3B  = 3'b000;
  localparam logic [2:0] F3H  = 3'b001;
  localparam logic [2:0] F3W  = 3'b010;
  localparam logic [2:0] F3Bu = 3'b100;
  localparam logic [2:0] F3Hu = 3'b101;

  // Access size is funct3[1:0].
  localparam logic [1:0] SizeB = 2'b00;
  localparam logic [1:0] SizeH = 2'b01;
  localparam logic [1:0] SizeW = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp,
    StDone
  } lsu_state_e;

  // True only for encodings that really touch memory; reserved funct3 values act as no-ops.
  function automatic logic is_mem_op(logic [6:0] op, logic [2:0] f3);
    if (op == OpLoad) return f3 inside {F3B, F3H, F3W, F3Bu, F3Hu};
    if (op == OpStore) return f3 inside {F3B, F3H, F3W};
    return 1'b0;
  endfunction

  function automatic logic misaligned(logic [1:0] size, logic [1:0] off);
    case (size)
      SizeH:   return off[0];
      SizeW:   return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_24090012_lsu_if.sv
// Data-memory bus between the LSU (master) and the memory (slave).
// req/we/addr/wdata/wstrb: request, held until gnt. gnt: request accepted.
// rvalid/rdata: response (read data or write ack), earliest one cycle after gnt.
interface ysyx_24090012_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ysyx_24090012_lsu_align.sv
// Combinational byte-lane logic for the LSU.
// off_i/funct3_i: byte offset and access type of the latched request.
// st_data_i -> st_lanes_o/st_strb_o: store data replicated to every lane plus byte enables.
// ld_word_i -> ld_data_o: selected load bytes, sign- or zero-extended.
module ysyx_24090012_lsu_align
  import ysyx_24090012_lsu_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] st_lanes_o,
  output logic [3:0]  st_strb_o,
  output logic [31:0] ld_data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted    = ld_word_i >> {off_i, 3'b000};
    st_lanes_o = st_data_i;
    st_strb_o  = 4'b1111;
    ld_data_o  = ld_word_i;
    unique case (funct3_i[1:0])
      SizeB: begin
        st_lanes_o = {4{st_data_i[7:0]}};
        st_strb_o  = 4'b0001 << off_i;
        // funct3[2] marks the unsigned variants
        ld_data_o  = funct3_i[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SizeH: begin
        st_lanes_o = {2{st_data_i[15:0]}};
        st_strb_o  = 4'b0011 << off_i;
        ld_data_o  = funct3_i[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_24090012_lsu.sv
// Load/store unit: responder for the EXU request port, master on the data-memory bus.
// clk_i/rst_ni: clock, asynchronous active-low reset.
// mem_valid_i/mem_addr_i/mem_wdata_i/exu_inst_i/exu_reg_num_i: EXU request, held until ready.
// mem_ready_o: one-cycle completion pulse. lsu_rdata_o/lsu_err_o/lsu_inst_o/lsu_reg_num_o:
// result, error flag and pass-through, held until the next accept.
// dmem_io: data-memory master port.
module ysyx_24090012_lsu
  import ysyx_24090012_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       mem_valid_i,
  input  logic [31:0]                mem_addr_i,
  input  logic [31:0]                mem_wdata_i,
  input  logic [31:0]                exu_inst_i,
  input  logic [63:0]                exu_reg_num_i,
  output logic                       mem_ready_o,
  output logic [31:0]                lsu_rdata_o,
  output logic [31:0]                lsu_inst_o,
  output logic [63:0]                lsu_reg_num_o,
  output logic                       lsu_err_o,
  ysyx_24090012_lsu_if.master        dmem_io
);

  // Counter runs 0..TIMEOUT_CYCLES-1 within one wait state.
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  lsu_state_e      state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     inst_q, inst_d;
  logic [63:0]     reg_num_q, reg_num_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [2:0]  in_f3;
  logic        in_mem, in_misal;
  logic        is_load, is_store;
  logic [31:0] st_lanes, ld_data;
  logic [3:0]  st_strb;

  assign in_f3    = exu_inst_i[14:12];
  assign in_mem   = is_mem_op(exu_inst_i[6:0], in_f3);
  assign in_misal = misaligned(in_f3[1:0], mem_addr_i[1:0]);
  assign is_load  = (inst_q[6:0] == OpLoad);
  assign is_store = (inst_q[6:0] == OpStore);

  ysyx_24090012_lsu_align u_align (
    .off_i      (addr_q[1:0]),
    .funct3_i   (inst_q[14:12]),
    .st_data_i  (wdata_q),
    .ld_word_i  (dmem_io.rdata),
    .st_lanes_o (st_lanes),
    .st_strb_o  (st_strb),
    .ld_data_o  (ld_data)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    inst_d    = inst_q;
    reg_num_d = reg_num_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (mem_valid_i) begin
          addr_d    = mem_addr_i;
          wdata_d   = mem_wdata_i;
          inst_d    = exu_inst_i;
          reg_num_d = exu_reg_num_i;
          rdata_d   = '0;
          err_d     = 1'b0;
          cnt_d     = '0;
          if (!in_mem) begin
            state_d = StDone;
          end else if (in_misal) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        // gnt wins over the timeout and over any rvalid seen in the same cycle
        if (dmem_io.gnt) begin
          cnt_d   = '0;
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        if (dmem_io.rvalid) begin
          rdata_d = is_load ? ld_data : 32'b0;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      inst_q    <= '0;
      reg_num_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      inst_q    <= inst_d;
      reg_num_q <= reg_num_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign mem_ready_o   = (state_q == StDone);
  assign lsu_rdata_o   = rdata_q;
  assign lsu_inst_o    = inst_q;
  assign lsu_reg_num_o = reg_num_q;
  assign lsu_err_o     = err_q;

  assign dmem_io.req   = (state_q == StReq);
  assign dmem_io.we    = is_store;
  assign dmem_io.addr  = {addr_q[31:2], 2'b00};
  assign dmem_io.wdata = st_lanes;
  assign dmem_io.wstrb = is_store ? st_strb : 4'b0000;

endmodule

// File: tb/tb_ysyx_24090012_lsu.sv
// Self-checking bench for ysyx_24090012_lsu: transaction-level reference model, one
// per-cycle compare process, directed cases with literal expectations, then random traffic.
module tb_ysyx_24090012_lsu;

  localparam int T = 4;

  localparam logic [31:0] InstAddi = 32'h0010_0093;
  localparam logic [31:0] InstLb   = 32'h0000_8083;
  localparam logic [31:0] InstLw   = 32'h0000_A083;
  localparam logic [31:0] InstLhu  = 32'h0000_D083;
  localparam logic [31:0] InstSh   = 32'h0020_9023;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata, exu_inst;
  logic [63:0] exu_reg_num;
  logic        mem_ready;
  logic [31:0] lsu_rdata, lsu_inst;
  logic [63:0] lsu_reg_num;
  logic        lsu_err;

  always #5 clk = ~clk;

  ysyx_24090012_lsu_if dmem_if ();

  ysyx_24090012_lsu #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .mem_valid_i   (mem_valid),
    .mem_addr_i    (mem_addr),
    .mem_wdata_i   (mem_wdata),
    .exu_inst_i    (exu_inst),
    .exu_reg_num_i (exu_reg_num),
    .mem_ready_o   (mem_ready),
    .lsu_rdata_o   (lsu_rdata),
    .lsu_inst_o    (lsu_inst),
    .lsu_reg_num_o (lsu_reg_num),
    .lsu_err_o     (lsu_err),
    .dmem_io       (dmem_if)
  );

  typedef struct {
    logic        mem;
    logic        err;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
  } exp_t;

  int n_tests = 0;
  int n_fail = 0;

  exp_t        cur;
  logic [31:0] cur_inst;
  logic [63:0] cur_tag;
  int          cur_rdy, cur_req_last, cyc;
  logic        active, chk_en;
  logic [31:0] h_rdata, h_inst;
  logic [63:0] h_tag;
  logic        h_err;
  int          obs_rdy, obs_req;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_strb;
  logic        seen_we;
  logic        exp_rdy, exp_req;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // What a request must do, straight from the ISA rules (timeouts applied by the caller).
  function automatic exp_t model(input logic [31:0] inst, addr, wdata, rword);
    exp_t        e;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        ld, st;
    int          size, off;
    logic [31:0] v, mask;
    op   = inst[6:0];
    f3   = inst[14:12];
    ld   = (op == 7'h03) && (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
    st   = (op == 7'h23) && (f3 < 3'd3);
    size = 1 << f3[1:0];
    off  = int'(addr[1:0]);
    e.err  = (ld || st) && ((addr % size) != 0);
    e.mem  = (ld || st) && !e.err;
    e.we   = st;
    e.addr = addr & 32'hFFFF_FFFC;
    for (int b = 0; b < 4; b++) begin
      e.strb[b]          = st && (b >= off) && (b < off + size);
      e.wdata[8*b +: 8]  = wdata[8*(b % size) +: 8];
    end
    v    = rword >> (8 * off);
    mask = (size >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
    v    = v & mask;
    if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
    e.rdata = (ld && e.mem) ? v : 32'h0;
    return e;
  endfunction

  // Issues one request; gw/rw are cycles the memory delays gnt/rvalid (>= T means never).
  task automatic run_txn(input logic [31:0] inst, addr, wdata, rword, input logic [63:0] tag,
                         input int gw, rw);
    exp_t e;
    int   gnt_c, rv_c, rdy_c, req_l, k;
    logic tmo;
    e     = model(inst, addr, wdata, rword);
    tmo   = 1'b0;
    gnt_c = -1;
    rv_c  = -1;
    if (!e.mem) begin
      rdy_c = 1;
      req_l = 0;
    end else if (gw >= T) begin
      req_l = T;
      rdy_c = T + 1;
      tmo   = 1'b1;
    end else begin
      gnt_c = gw + 1;
      req_l = gnt_c;
      if (rw >= T) begin
        rdy_c = gnt_c + T + 1;
        tmo   = 1'b1;
      end else begin
        rv_c  = gnt_c + rw + 1;
        rdy_c = rv_c + 1;
      end
    end
    if (tmo) begin
      e.err   = 1'b1;
      e.rdata = 32'h0;
    end
    cur          = e;
    cur_inst     = inst;
    cur_tag      = tag;
    cur_rdy      = rdy_c;
    cur_req_last = req_l;
    obs_rdy      = -1;
    obs_req      = 0;
    mem_valid    = 1'b1;
    mem_addr     = addr;
    mem_wdata    = wdata;
    exu_inst     = inst;
    exu_reg_num  = tag;
    cyc          = 0;
    active       = 1'b1;
    for (int j = 0; j <= rdy_c; j++) begin
      @(posedge clk);
      #1;
      cyc = j + 1;
      k   = j + 1;
      if (j == rdy_c) begin
        mem_valid      = 1'b0;
        active         = 1'b0;
        dmem_if.gnt    = ($urandom_range(1) == 1);
        dmem_if.rvalid = ($urandom_range(1) == 1);
      end else begin
        // Stray gnt only outside REQ, stray rvalid only outside RESP (incl. gnt+rvalid cycle).
        dmem_if.gnt    = (k == gnt_c) || (k > req_l && $urandom_range(1) == 1);
        dmem_if.rvalid = (k == rv_c) ||
                         ((k <= req_l || k >= rdy_c) && $urandom_range(1) == 1);
        dmem_if.rdata  = (k == rv_c) ? rword : $urandom;
        // Request inputs change after accept; the LSU must work from its latched copy.
        mem_addr       = $urandom;
        mem_wdata      = $urandom;
        exu_inst       = $urandom;
        exu_reg_num    = {$urandom, $urandom};
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      exp_rdy = active && (cyc == cur_rdy);
      exp_req = active && cur.mem && (cyc >= 1) && (cyc <= cur_req_last);
      chk("mem_ready", mem_ready, exp_rdy);
      chk("dmem_req", dmem_if.req, exp_req);
      if (active && dmem_if.req) obs_req++;
      if (active && mem_ready && obs_rdy < 0) obs_rdy = cyc;
      if (dmem_if.req) begin
        seen_addr  = dmem_if.addr;
        seen_wdata = dmem_if.wdata;
        seen_strb  = dmem_if.wstrb;
        seen_we    = dmem_if.we;
      end
      if (exp_req) begin
        chk("dmem_addr", dmem_if.addr, cur.addr);
        chk("dmem_we", dmem_if.we, cur.we);
        chk("dmem_wstrb", dmem_if.wstrb, cur.strb);
        if (cur.we) chk("dmem_wdata", dmem_if.wdata, cur.wdata);
      end
      if (exp_rdy) begin
        chk("lsu_rdata", lsu_rdata, cur.rdata);
        chk("lsu_err", lsu_err, cur.err);
        chk("lsu_inst", lsu_inst, cur_inst);
        chk("lsu_reg_num", lsu_reg_num, cur_tag);
        h_rdata = cur.rdata;
        h_err   = cur.err;
        h_inst  = cur_inst;
        h_tag   = cur_tag;
      end else if (!active || cyc == 0) begin
        chk("hold_rdata", lsu_rdata, h_rdata);
        chk("hold_err", lsu_err, h_err);
        chk("hold_inst", lsu_inst, h_inst);
        chk("hold_reg_num", lsu_reg_num, h_tag);
      end
    end
  end

  initial begin
    logic [31:0] r_inst, r_addr;
    logic [6:0]  op;
    int          gw, rw;
    mem_valid      = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    exu_inst       = '0;
    exu_reg_num    = '0;
    dmem_if.gnt    = 1'b0;
    dmem_if.rvalid = 1'b0;
    dmem_if.rdata  = '0;
    chk_en         = 1'b0;
    active         = 1'b0;
    cyc            = 0;
    cur_rdy        = 0;
    cur_req_last   = 0;
    cur            = '{mem: 1'b0, err: 1'b0, we: 1'b0, addr: '0, wdata: '0, strb: '0, rdata: '0};
    h_rdata        = '0;
    h_err          = 1'b0;
    h_inst         = '0;
    h_tag          = '0;
    obs_rdy        = -1;
    obs_req        = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", mem_ready, 0);
    chk("rst_req", dmem_if.req, 0);
    chk("rst_rdata", lsu_rdata, 0);
    chk("rst_err", lsu_err, 0);
    chk("rst_inst", lsu_inst, 0);
    chk("rst_reg_num", lsu_reg_num, 0);
    chk("rst_wstrb", dmem_if.wstrb, 0);
    chk("rst_we", dmem_if.we, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    // Non-memory instruction completes one cycle after accept.
    run_txn(InstAddi, 32'h8000_0000, 32'h5555_5555, 32'hDEAD_BEEF, 64'h1, 0, 0);
    chk("t1_latency", obs_rdy, 1);
    chk("t1_err", lsu_err, 0);
    chk("t1_no_req", obs_req, 0);
    chk("t1_rdata", lsu_rdata, 0);

    // LB from the top byte, immediate gnt/rvalid.
    run_txn(InstLb, 32'h8000_0003, 32'h0, 32'h8000_0000, 64'h2, 0, 0);
    chk("t2_rdata", lsu_rdata, 32'hFFFF_FF80);
    chk("t2_latency", obs_rdy, 3);

    // SH to the upper halfword.
    run_txn(InstSh, 32'h8000_0002, 32'h1234_ABCD, 32'h0, 64'h3, 1, 1);
    chk("t3_addr", seen_addr, 32'h8000_0000);
    chk("t3_wdata", seen_wdata, 32'hABCD_ABCD);
    chk("t3_wstrb", seen_strb, 4'b1100);
    chk("t3_we", seen_we, 1);

    // Misaligned LW aborts without touching memory.
    run_txn(InstLw, 32'h8000_0001, 32'h0, 32'h0, 64'h4, 0, 0);
    chk("t4_err", lsu_err, 1);
    chk("t4_latency", obs_rdy, 1);
    chk("t4_no_req", obs_req, 0);

    // gnt never arrives: request held T cycles, then error completion.
    run_txn(InstLw, 32'h8000_0010, 32'h0, 32'h1111_2222, 64'h5, 100, 0);
    chk("t5_req_cycles", obs_req, T);
    chk("t5_latency", obs_rdy, T + 1);
    chk("t5_err", lsu_err, 1);
    chk("t5_rdata", lsu_rdata, 0);

    // Reset while waiting for the response.
    chk_en         = 1'b0;
    mem_valid      = 1'b1;
    exu_inst       = InstLw;
    mem_addr       = 32'h0000_0100;
    exu_reg_num    = 64'hABCD;
    dmem_if.gnt    = 1'b1;
    dmem_if.rvalid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    dmem_if.gnt = 1'b0;
    mem_valid   = 1'b0;
    rst_n       = 1'b0;
    #1;
    chk("t6_req", dmem_if.req, 0);
    chk("t6_ready", mem_ready, 0);
    chk("t6_inst", lsu_inst, 0);
    chk("t6_reg_num", lsu_reg_num, 0);
    chk("t6_rdata", lsu_rdata, 0);
    @(negedge clk);
    rst_n   = 1'b1;
    active  = 1'b0;
    cur.mem = 1'b0;
    h_rdata = '0;
    h_err   = 1'b0;
    h_inst  = '0;
    h_tag   = '0;
    chk_en  = 1'b1;
    @(posedge clk);
    #1;
    run_txn(InstLhu, 32'h0000_0002, 32'h0, 32'hF00D_0000, 64'h6, 0, 0);
    chk("t6_lhu_rdata", lsu_rdata, 32'h0000_F00D);
    chk("t6_lhu_err", lsu_err, 0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(3))
        0:       op = 7'b0000011;
        1:       op = 7'b0100011;
        2:       op = 7'b0010011;
        default: op = 7'($urandom);
      endcase
      r_inst      = $urandom;
      r_inst[6:0] = op;
      r_addr      = $urandom;
      if ($urandom_range(1) == 1) begin
        if (r_inst[13]) r_addr[1:0] = 2'b00;
        else if (r_inst[12]) r_addr[0] = 1'b0;
      end
      gw = ($urandom_range(7) == 0) ? T + int'($urandom_range(2)) : int'($urandom_range(3));
      rw = ($urandom_range(7) == 0) ? T + int'($urandom_range(2)) : int'($urandom_range(3));
      run_txn(r_inst, r_addr, $urandom, $urandom, {$urandom, $urandom}, gw, rw);
      if ($urandom_range(3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
